// File: rtl/core_run_ctrl.sv
// Host-side run sequencer: preloads dat_mem, starts the core, times the run,
// then streams a result window of dat_mem back to the host.
`timescale 1ns/1ps
module core_run_ctrl #(
  parameter int unsigned AW       = 8,
  parameter int unsigned LOAD_N   = 64,
  parameter int unsigned RES_BASE = 64,
  parameter int unsigned RES_N    = 4,
  parameter int unsigned CW       = 16,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_host_sel,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wr_data,
  input  logic [7:0]    mem_rd_data,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          out_valid,
  output logic [7:0]    out_data,
  input  logic          out_ready,
  output logic          busy,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DRAIN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_idx;
  logic [CW-1:0] r_cycles;
  logic          r_timeout;
  logic          r_core_reset;
  logic          r_host_sel;
  logic          r_core_req;
  logic          r_busy;
  logic          r_in_ready;
  logic          r_out_valid;

  logic          w_in_acc;
  logic          w_out_acc;
  logic [CW-1:0] w_cyc_inc;

  assign w_in_acc  = r_in_ready & in_valid;
  assign w_out_acc = r_out_valid & out_ready;
  assign w_cyc_inc = r_cycles + CW'(1);

  // Handshake-qualified signals stay combinational so a byte is written the
  // same cycle it is accepted; all state-level outputs are registered below.
  always_comb begin
    mem_wr_en   = w_in_acc;
    mem_wr_data = w_in_acc ? in_data : '0;
    out_data    = r_out_valid ? mem_rd_data : '0;
    case (r_state)
      S_LOAD:  mem_addr = r_idx;
      S_DRAIN: mem_addr = AW'(RES_BASE) + r_idx;
      default: mem_addr = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cycles     <= '0;
      r_timeout    <= 1'b0;
      r_core_reset <= 1'b1;
      r_host_sel   <= 1'b1;
      r_core_req   <= 1'b0;
      r_busy       <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_timeout  <= 1'b0;
            r_idx      <= '0;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_in_acc) begin
            r_idx <= r_idx + AW'(1);
            if (r_idx == AW'(LOAD_N - 1)) begin
              r_in_ready   <= 1'b0;
              r_core_reset <= 1'b0;
              r_host_sel   <= 1'b0;
              r_core_req   <= 1'b1;
              r_state      <= S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          r_cycles   <= '0;
          r_core_req <= 1'b0;
          r_state    <= S_RUN;
        end
        S_RUN: begin
          // core_done wins over a timeout landing in the same cycle
          if (core_done || (w_cyc_inc == CW'(TIMEOUT))) begin
            if (!core_done) begin
              r_cycles  <= w_cyc_inc;
              r_timeout <= 1'b1;
            end
            r_idx        <= '0;
            r_core_reset <= 1'b1;
            r_host_sel   <= 1'b1;
            r_out_valid  <= 1'b1;
            r_state      <= S_DRAIN;
          end else begin
            r_cycles <= w_cyc_inc;
          end
        end
        S_DRAIN: begin
          if (w_out_acc) begin
            r_idx <= r_idx + AW'(1);
            if (r_idx == AW'(RES_N - 1)) begin
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign mem_host_sel = r_host_sel;
  assign core_reset   = r_core_reset;
  assign core_req     = r_core_req;
  assign out_valid    = r_out_valid;
  assign busy         = r_busy;
  assign timeout      = r_timeout;
  assign cycles       = r_cycles;

endmodule
